lsu_wb_master: RTL
==================

Name: lsu_wb_master

Overview:
- Load/store unit between the CPU execute stage and the word-organised Wishbone data memory.
- Converts one RV32I load/store request (funct3, byte address, store data) into a single Wishbone word access with byte selects. Returns sign- or zero-extended load data.
- Detects misaligned or illegal accesses locally; these never reach the bus.

Parameters:
- WORD_ADDR, 1: 1 = o_wb_addr is the word index (i_addr>>2); 0 = o_wb_addr is the byte address with [1:0] forced to 0.
- TIMEOUT_CYCLES, 255: ack watchdog limit; used only when LSU_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req  in  1  request strobe from CPU, sampled only in S_IDLE
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32I load/store funct3
- i_addr  in  32  byte address
- i_wdata  in  32  store data (rs2)
- o_busy  out  1  high from the cycle after accept until o_done
- o_done  out  1  one-cycle completion pulse
- o_fault  out  1  valid with o_done: misaligned, illegal funct3, or timeout
- o_rdata  out  32  extended load data, valid with o_done on loads; held until next done
- o_wb_stb  out  1  Wishbone strobe
- o_wb_we  out  1  Wishbone write enable
- o_wb_addr  out  32  Wishbone address
- o_wb_data  out  32  write data, lane-replicated
- o_wb_sel  out  4  byte lane selects
- i_wb_data  in  32  read data
- i_wb_ack  in  1  slave acknowledge
- i_wb_stall  in  1  slave stall

Behaviour:
- Reset values: all outputs 0; state S_IDLE; watchdog counter 0.
- Reset taken in any state, mid-transaction included. Any ack arriving afterwards is ignored in S_IDLE.
- States: S_IDLE, S_REQ, S_WAIT, S_DONE.
- S_IDLE:
  - On i_req, latch we/funct3/addr/wdata and set o_busy=1.
  - Legal and aligned: drive the bus outputs, set o_wb_stb=1, go to S_REQ.
  - Otherwise: o_fault=1, go to S_DONE with no bus cycle.
- Legality:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: funct3 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- Byte selects: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111. The same selects are driven for loads.
- Store data: byte replicated ×4; half replicated ×2; word as is.
- S_REQ:
  - At a clock edge with o_wb_stb && !i_wb_stall, drop o_wb_stb and go to S_WAIT.
  - stb is high for exactly one accepted cycle, so the slave never sees a second request.
  - If i_wb_ack arrives in S_REQ, treat it as completion.
- Bus outputs: o_wb_we/addr/data/sel are held stable from S_REQ until ack; the slave reads sel during its write phase.
- S_WAIT: on i_wb_ack, capture i_wb_data and go to S_DONE.
- Load extraction: shift right by 8*addr[1:0], then take the low byte/half. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- S_DONE: o_done=1 for one cycle, o_busy=0, return to S_IDLE.
- i_req asserted in the S_DONE cycle is not accepted; it is accepted on the following S_IDLE cycle.
- Latency against a 2-cycle-internal slave: accept edge 0, stb accepted edge 1, ack seen edge 4, o_done high after edge 4.
- o_fault is cleared on each accept and updated only in S_DONE.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - Counter runs in S_REQ/S_WAIT and clears on accept.
  - On reaching TIMEOUT_CYCLES without ack: drop stb, go to S_DONE with o_fault=1; o_rdata is unchanged.
- Undefined: no counter; the LSU waits indefinitely for ack.

Test Plan:
- SW addr 0x00000008, data 0xDEADBEEF -> o_wb_addr=2, sel=1111, data=0xDEADBEEF; one stb accept; done, fault=0; readback LW = 0xDEADBEEF.
- SB addr 0x0000000B, data 0x000000A5 -> sel=1000, o_wb_data=0xA5A5A5A5; then LW 0x8 = 0xA5ADBEEF.
- LB/LBU/LH/LHU on word 0x80F0_7F81 -> LB@0 = 0xFFFFFF81; LBU@0 = 0x00000081; LH@2 = 0xFFFF80F0; LHU@2 = 0x000080F0.
- LW addr 0x6; LH addr 0x1; funct3 011 -> o_wb_stb never asserted; done 2 cycles after req with fault=1.
- Hold i_wb_stall=1 for 3 cycles, then release -> stb held 4 cycles, single accept, correct data. Assert i_reset while in S_WAIT -> all outputs 0; a late ack produces no done.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> done with fault=1 after the limit, stb low, o_rdata unchanged.

Source files
------------

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: RV32I load/store unit driving a word-organised Wishbone data port.
//
// One CPU request (funct3, byte address, store data) becomes a single Wishbone word access
// with byte lane selects. Load data is shifted down to the addressed lane and sign- or
// zero-extended. Misaligned or illegal requests fault locally and never reach the bus.
//
// Optional build macro:
//   LSU_TIMEOUT_EN - adds an ack watchdog. If no ack arrives within TIMEOUT_CYCLES
//                    cycles, the access completes with a fault. Without the macro the
//                    unit waits for ack indefinitely.
//
// Parameters:
//   WORD_ADDR      1: o_wb_addr is the word index; 0: o_wb_addr is the byte address with [1:0]=0
//   TIMEOUT_CYCLES ack watchdog limit (only with LSU_TIMEOUT_EN)
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_req, i_we, i_funct3    request strobe (sampled in idle), store flag, RV32I funct3
//   i_addr, i_wdata          byte address, store data
//   o_busy, o_done, o_fault  busy, one-cycle completion pulse, fault flag valid with o_done
//   o_rdata                  extended load data, held until the next load completion
//   o_wb_*                   Wishbone master outputs (stb, we, addr, data, sel)
//   i_wb_data/ack/stall      Wishbone slave responses
module lsu_wb_master #(
   parameter bit          WORD_ADDR      = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_fault,
   output logic [31:0] o_rdata,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic [31:0] i_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      r_state;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;

   logic        w_legal;
   logic        w_aligned;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata;
   logic [31:0] w_wb_addr;
   logic [31:0] w_shift;
   logic [31:0] w_load;
   logic        w_timeout;

   // Request decode, evaluated on the live request inputs in S_IDLE.
   always_comb begin
      w_legal = 1'b0;
      case (i_funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = !i_we;  // unsigned variants exist for loads only
         default:                w_legal = 1'b0;
      endcase

      w_aligned = 1'b1;
      w_sel     = 4'b1111;
      w_wdata   = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            w_sel   = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_aligned = !i_addr[0];
            w_sel     = 4'b0011 << i_addr[1:0];
            w_wdata   = {2{i_wdata[15:0]}};
         end
         default: begin
            w_aligned = (i_addr[1:0] == 2'b00);
         end
      endcase

      w_wb_addr = WORD_ADDR ? {2'b00, i_addr[31:2]} : {i_addr[31:2], 2'b00};
   end

   // Load extraction: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      w_shift = i_wb_data >> {r_off, 3'b000};
      case (r_funct3)
         3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_load = {24'd0, w_shift[7:0]};
         3'b101:  w_load = {16'd0, w_shift[15:0]};
         default: w_load = w_shift;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   logic [31:0] r_wdt;
   // Counter holds the number of cycles already spent in S_REQ/S_WAIT.
   assign w_timeout = (r_wdt >= TIMEOUT_CYCLES - 1);
`else
   // Watchdog compiled out; the parameter is referenced so both builds share one interface.
   assign w_timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_we      <= 1'b0;
         r_funct3  <= 3'd0;
         r_off     <= 2'd0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_fault   <= 1'b0;
         o_rdata   <= 32'd0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= 32'd0;
         o_wb_data <= 32'd0;
         o_wb_sel  <= 4'd0;
`ifdef LSU_TIMEOUT_EN
         r_wdt     <= 32'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_we     <= i_we;
                  r_funct3 <= i_funct3;
                  r_off    <= i_addr[1:0];
                  o_busy   <= 1'b1;
                  o_fault  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                  r_wdt    <= 32'd0;
`endif
                  if (w_legal && w_aligned) begin
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= i_we;
                     o_wb_addr <= w_wb_addr;
                     o_wb_data <= w_wdata;
                     o_wb_sel  <= w_sel;
                     r_state   <= S_REQ;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end

            S_REQ, S_WAIT: begin
`ifdef LSU_TIMEOUT_EN
               r_wdt <= r_wdt + 32'd1;
`endif
               // An ack while still strobing is a valid completion too.
               if (i_wb_ack) begin
                  o_wb_stb <= 1'b0;
                  o_done   <= 1'b1;
                  o_busy   <= 1'b0;
                  if (!r_we) begin
                     o_rdata <= w_load;
                  end
                  r_state  <= S_DONE;
               end else if (w_timeout) begin
                  o_wb_stb <= 1'b0;
                  o_done   <= 1'b1;
                  o_busy   <= 1'b0;
                  o_fault  <= 1'b1;
                  r_state  <= S_DONE;
               end else if ((r_state == S_REQ) && !i_wb_stall) begin
                  // Strobe accepted: drop it so the slave sees exactly one request.
                  o_wb_stb <= 1'b0;
                  r_state  <= S_WAIT;
               end
            end

            S_DONE: begin
               if (o_done) begin
                  o_done  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  // Reached straight from S_IDLE: a locally detected fault.
                  o_done  <= 1'b1;
                  o_busy  <= 1'b0;
                  o_fault <= 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
